// File: rtl/disp_scan_ctrl.sv
// Multiplexed display scan controller: Avalon-MM register file plus a BLANK/DRIVE digit scanner.
// Optional blink support is compiled in with `define DISP_SCAN_BLINK_EN.
module disp_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int BLINK_DIV  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  enable_q, enable_d;
    logic [7:0]            digit_q [NUM_DIGITS];
    logic [7:0]            digit_d [NUM_DIGITS];
    logic [7:0]            seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

    logic       wr_en;
    logic [7:0] cur_digit;
    logic [7:0] drive_seg;
    logic       idx_wrap;
    logic       unused_bits;

`ifdef DISP_SCAN_BLINK_EN
    localparam int FR_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FR_W-1:0] FRAME_LAST = FR_W'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0] blink_mask_q, blink_mask_d;
    logic [FR_W-1:0]       frame_q, frame_d;
    logic                  phase_q, phase_d;
    logic                  cur_masked;
`endif

    assign wr_en       = chipselect && !write_n;
    assign idx_wrap    = (idx_q == IDX_LAST);
    assign unused_bits = ^{writedata[31:8], BLINK_DIV > 0};
    assign seg_out     = seg_out_q;
    assign dig_sel     = dig_sel_q;

    always_comb begin
        cur_digit = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = digit_q[i];
        end
    end

`ifdef DISP_SCAN_BLINK_EN
    always_comb begin
        cur_masked = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_masked = blink_mask_q[i];
        end
    end
    assign drive_seg = (phase_q && cur_masked) ? 8'h00 : cur_digit;
`else
    assign drive_seg = cur_digit;
`endif

    // Register writes; CTRL/BLINK_MASK addresses take precedence over digit slots 4..7.
    always_comb begin
        enable_d = enable_q;
        digit_d  = digit_q;
        if (wr_en && address == 3'd4) enable_d = writedata[0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en && address == 3'(i) && address < 3'd4) digit_d[i] = writedata[7:0];
        end
    end

`ifdef DISP_SCAN_BLINK_EN
    always_comb begin
        blink_mask_d = blink_mask_q;
        if (wr_en && address == 3'd5) blink_mask_d = writedata[NUM_DIGITS-1:0];
    end
`endif

    always_comb begin
        readdata = 32'h0;
        if (address == 3'd4) begin
            readdata = {15'd0, state_q != IDLE, 5'd0, 3'(idx_q), 7'd0, enable_q};
        end else if (address == 3'd5) begin
`ifdef DISP_SCAN_BLINK_EN
            readdata = {{(32-NUM_DIGITS){1'b0}}, blink_mask_q};
`else
            readdata = 32'h0;
`endif
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == 3'(i)) readdata = {24'd0, digit_q[i]};
            end
        end
    end

    // Scan FSM: outputs are computed for the next state so they come straight off flops.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        seg_out_d = 8'h00;
        dig_sel_d = '0;
`ifdef DISP_SCAN_BLINK_EN
        frame_d   = frame_q;
        phase_d   = phase_q;
`endif
        if (!enable_q) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
`ifdef DISP_SCAN_BLINK_EN
            frame_d = '0;
            phase_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef DISP_SCAN_BLINK_EN
                    frame_d = '0;
                    phase_d = 1'b0;
`endif
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d   = DRIVE;
                        dig_sel_d = NUM_DIGITS'(1) << idx_q;
                        seg_out_d = drive_seg;
                    end
                end
                DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_wrap ? '0 : idx_q + 1'b1;
`ifdef DISP_SCAN_BLINK_EN
                        if (idx_wrap) begin
                            if (frame_q == FRAME_LAST) begin
                                frame_d = '0;
                                phase_d = !phase_q;
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end
`endif
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        dig_sel_d = NUM_DIGITS'(1) << idx_q;
                        seg_out_d = drive_seg;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            enable_q     <= 1'b0;
            digit_q      <= '{default: 8'h00};
            seg_out_q    <= 8'h00;
            dig_sel_q    <= '0;
`ifdef DISP_SCAN_BLINK_EN
            blink_mask_q <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            enable_q     <= enable_d;
            digit_q      <= digit_d;
            seg_out_q    <= seg_out_d;
            dig_sel_q    <= dig_sel_d;
`ifdef DISP_SCAN_BLINK_EN
            blink_mask_q <= blink_mask_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=2.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int         zrun     = 0;
    logic [3:0] last_dig = 4'h0;

    disp_scan_ctrl #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .BLINK_DIV (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic outs(input string tag, input logic [3:0] d, input logic [7:0] s);
        check({tag, "_dig"}, 32'(dig_sel), 32'(d));
        check({tag, "_seg"}, 32'(seg_out), 32'(s));
    endtask

    // Continuous one-hot and inter-digit blanking monitor.
    always @(negedge clk) begin
        if (reset_n) begin
            check("onehot", 32'($onehot0(dig_sel)), 32'd1);
            if (dig_sel != 4'h0) begin
                if (last_dig != 4'h0 && dig_sel != last_dig)
                    check("gap", 32'(zrun >= 2), 32'd1);
                last_dig = dig_sel;
                zrun     = 0;
            end else begin
                zrun++;
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int a = 0; a < 6; a++) rd("rst_rd", 3'(a), 32'h0);
        outs("rst", 4'h0, 8'h00);

        wr(3'd0, 32'h3F);
        wr(3'd1, 32'h06);
        wr(3'd2, 32'h5B);
        wr(3'd3, 32'h4F);
        rd("digit2_rd", 3'd2, 32'h5B);

        wr(3'd4, 32'h1);
        cyc = 0;
        rd("ctrl_E", 3'd4, 32'h0000_0001);
        to(1);
        rd("ctrl_blank", 3'd4, 32'h0001_0001);
        outs("blank1", 4'h0, 8'h00);
        to(2);
        outs("blank2", 4'h0, 8'h00);
        for (int n = 3; n <= 8; n++) begin
            to(n);
            outs("slot0", 4'h1, 8'h3F);
        end
        to(9);
        outs("gap0a", 4'h0, 8'h00);
        to(10);
        outs("gap0b", 4'h0, 8'h00);
        to(11);
        outs("slot1", 4'h2, 8'h06);
        rd("ctrl_idx1", 3'd4, 32'h0001_0101);

        to(12);
        wr(3'd1, 32'h7F);
        check("live_nogap", 32'(dig_sel), 32'h2);
        to(14);
        outs("live", 4'h2, 8'h7F);

        to(19);
        outs("slot2", 4'h4, 8'h5B);
        to(27);
        outs("slot3", 4'h8, 8'h4F);
        to(33);
        outs("gap3", 4'h0, 8'h00);
        to(35);
        outs("wrap", 4'h1, 8'h3F);
        rd("ctrl_wrap", 3'd4, 32'h0001_0001);
        to(43);
        outs("slot1b", 4'h2, 8'h7F);
        to(51);
        outs("slot2b", 4'h4, 8'h5B);

        to(52);
        wr(3'd4, 32'h0);
        check("dis_same", 32'(dig_sel), 32'h4);
        to(54);
        outs("dis", 4'h0, 8'h00);
        rd("ctrl_dis", 3'd4, 32'h0);

        to(56);
        wr(3'd4, 32'h1);
        cyc = 0;
        to(1);
        outs("re_b1", 4'h0, 8'h00);
        to(2);
        outs("re_b2", 4'h0, 8'h00);
        to(3);
        outs("re_d0", 4'h1, 8'h3F);
        rd("ctrl_re", 3'd4, 32'h0001_0001);

        wr(3'd5, 32'hF);
`ifdef DISP_SCAN_BLINK_EN
        rd("addr5", 3'd5, 32'hF);
`else
        rd("addr5", 3'd5, 32'h0);
`endif
        wr(3'd6, 32'hAB);
        rd("addr6", 3'd6, 32'h0);
        rd("addr7", 3'd7, 32'h0);

`ifdef DISP_SCAN_BLINK_EN
        wr(3'd4, 32'h0);
        tick();
        tick();
        wr(3'd1, 32'h06);
        wr(3'd5, 32'h2);
        wr(3'd4, 32'h1);
        cyc = 0;
        to(11);
        outs("bl_f0", 4'h2, 8'h06);
        to(43);
        outs("bl_f1", 4'h2, 8'h06);
        to(67);
        outs("bl_f2d0", 4'h1, 8'h3F);
        to(75);
        outs("bl_f2d1", 4'h2, 8'h00);
        to(83);
        outs("bl_f2d2", 4'h4, 8'h5B);
        to(107);
        outs("bl_f3d1", 4'h2, 8'h00);
        to(139);
        outs("bl_f4d1", 4'h2, 8'h06);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
